// File: rtl/reg_f_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_f_arbiter_if
// Bundles the two requester channels (A, B) and the register-file side of the
// reg_f arbiter into one interface.
//   x_REQ/x_WE/x_SEL/x_WDATA : requester x command (x in A, B)
//   x_GNT/x_RDATA/x_DONE/x_ERR : grant and response back to requester x
//   REG_F_SEL/EN_REG_F/REG_IN  : select, write enable and write data to reg_f
//   REG_OUT                    : read data from reg_f
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the register file)
// -----------------------------------------------------------------------------
interface reg_f_arbiter_if #(
  parameter int WIDTH          = 8,
  parameter int REG_F_SEL_SIZE = 4
);
  logic                      A_REQ;
  logic                      A_WE;
  logic [REG_F_SEL_SIZE-1:0] A_SEL;
  logic [WIDTH-1:0]          A_WDATA;
  logic                      A_GNT;
  logic [WIDTH-1:0]          A_RDATA;
  logic                      A_DONE;
  logic                      A_ERR;

  logic                      B_REQ;
  logic                      B_WE;
  logic [REG_F_SEL_SIZE-1:0] B_SEL;
  logic [WIDTH-1:0]          B_WDATA;
  logic                      B_GNT;
  logic [WIDTH-1:0]          B_RDATA;
  logic                      B_DONE;
  logic                      B_ERR;

  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL;
  logic                      EN_REG_F;
  logic [WIDTH-1:0]          REG_IN;
  logic [WIDTH-1:0]          REG_OUT;

  modport slave (
    input  A_REQ, A_WE, A_SEL, A_WDATA,
    input  B_REQ, B_WE, B_SEL, B_WDATA,
    input  REG_OUT,
    output A_GNT, A_RDATA, A_DONE, A_ERR,
    output B_GNT, B_RDATA, B_DONE, B_ERR,
    output REG_F_SEL, EN_REG_F, REG_IN
  );

  modport master (
    output A_REQ, A_WE, A_SEL, A_WDATA,
    output B_REQ, B_WE, B_SEL, B_WDATA,
    output REG_OUT,
    input  A_GNT, A_RDATA, A_DONE, A_ERR,
    input  B_GNT, B_RDATA, B_DONE, B_ERR,
    input  REG_F_SEL, EN_REG_F, REG_IN
  );
endinterface

// File: rtl/reg_f_arbiter.sv
// -----------------------------------------------------------------------------
// reg_f_arbiter
// Two-requester arbiter in front of a single-port register file (reg_f).
// One owner at a time (IDLE / OWN_A / OWN_B). Each cycle the owner holds its
// request is one access: the command is steered combinationally to reg_f,
// and DONE (plus ERR for an out-of-range index, plus RDATA for reads) is
// returned one cycle later from registers. Ties go to the requester not
// served last; an owner is forced off after MAX_HOLD accesses if the other
// side is waiting.
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset
//   bus  - reg_f_arbiter_if.slave (requester A/B channels + reg_f side)
// -----------------------------------------------------------------------------
module reg_f_arbiter #(
  parameter int WIDTH          = 8,
  parameter int REG_SIZE       = 9,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int MAX_HOLD       = 4
) (
  input  logic           CLK,
  input  logic           RST,
  reg_f_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  // One extra bit so REG_SIZE == 2**REG_F_SEL_SIZE still compares correctly.
  localparam logic [REG_F_SEL_SIZE:0] REG_LIMIT = (REG_F_SEL_SIZE+1)'(REG_SIZE);
  localparam logic [3:0]              HOLD_MAX  = 4'(MAX_HOLD);

  state_e             state_q, state_d;
  logic               last_b_q, last_b_d;   // 1: B was served last
  logic [3:0]         hold_q, hold_d;
  logic               a_done_q, a_done_d;
  logic               b_done_q, b_done_d;
  logic               a_err_q, a_err_d;
  logic               b_err_q, b_err_d;
  logic [WIDTH-1:0]   a_rdata_q, a_rdata_d;
  logic [WIDTH-1:0]   b_rdata_q, b_rdata_d;

  // Owner-side command mux
  logic                      own_a, own_b;
  logic                      own_req, oth_req, own_we;
  logic [REG_F_SEL_SIZE-1:0] own_sel;
  logic [WIDTH-1:0]          own_wdata;
  logic                      access, sel_ok;
  logic [3:0]                hold_inc;

  assign own_a = (state_q == OWN_A);
  assign own_b = (state_q == OWN_B);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    own_req   = 1'b0;
    oth_req   = 1'b0;
    own_we    = 1'b0;
    own_sel   = '0;
    own_wdata = '0;
    if (own_a) begin
      own_req   = bus.A_REQ;
      oth_req   = bus.B_REQ;
      own_we    = bus.A_WE;
      own_sel   = bus.A_SEL;
      own_wdata = bus.A_WDATA;
    end else if (own_b) begin
      own_req   = bus.B_REQ;
      oth_req   = bus.A_REQ;
      own_we    = bus.B_WE;
      own_sel   = bus.B_SEL;
      own_wdata = bus.B_WDATA;
    end
  end

  // An access in a reset cycle is aborted: no write, no response.
  assign access   = own_req & ~RST;
  assign sel_ok   = ({1'b0, own_sel} < REG_LIMIT);
  // Hold count including this cycle's access, saturating at MAX_HOLD.
  assign hold_inc = (access && hold_q != HOLD_MAX) ? hold_q + 4'd1 : hold_q;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.A_REQ && bus.B_REQ) state_d = last_b_q ? OWN_A : OWN_B;
        else if (bus.A_REQ)         state_d = OWN_A;
        else if (bus.B_REQ)         state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (!own_req)
          state_d = oth_req ? (own_a ? OWN_B : OWN_A) : IDLE;
        // Forced handoff: this cycle's access still completes.
        else if (oth_req && hold_inc == HOLD_MAX)
          state_d = own_a ? OWN_B : OWN_A;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWN_A && state_q != OWN_A) last_b_d = 1'b0;
    if (state_d == OWN_B && state_q != OWN_B) last_b_d = 1'b1;
  end

  assign hold_d = (state_d != state_q) ? 4'd0 : hold_inc;

  // Response next-state: only the owner's side ever changes.
  assign a_done_d  = access & own_a;
  assign b_done_d  = access & own_b;
  assign a_err_d   = access & own_a & ~sel_ok;
  assign b_err_d   = access & own_b & ~sel_ok;
  assign a_rdata_d = (access && own_a && !own_we && sel_ok) ? bus.REG_OUT : a_rdata_q;
  assign b_rdata_d = (access && own_b && !own_we && sel_ok) ? bus.REG_OUT : b_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      hold_q    <= 4'd0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      hold_q    <= hold_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Grants decode the state register directly.
  assign bus.A_GNT   = own_a;
  assign bus.B_GNT   = own_b;
  assign bus.A_DONE  = a_done_q;
  assign bus.B_DONE  = b_done_q;
  assign bus.A_ERR   = a_err_q;
  assign bus.B_ERR   = b_err_q;
  assign bus.A_RDATA = a_rdata_q;
  assign bus.B_RDATA = b_rdata_q;

  // reg_f side: driven only while the owner is accessing.
  assign bus.EN_REG_F  = access & own_we & sel_ok;
  assign bus.REG_F_SEL = access ? own_sel   : '0;
  assign bus.REG_IN    = access ? own_wdata : '0;

endmodule

// File: tb/tb_reg_f_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_f_arbiter
// Directed vector table for the main scenarios (write/read, bad index, tie,
// forced handoff, reset mid-burst), followed by a randomized run checked
// against a rule-level reference model. A small register file is modelled
// behind the arbiter's reg_f port.
// -----------------------------------------------------------------------------
module tb_reg_f_arbiter;

  localparam int WIDTH    = 8;
  localparam int REG_SIZE = 9;
  localparam int SEL_W    = 4;
  localparam int MAX_HOLD = 4;
  localparam int N_RAND   = 3000;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  always #5 clk = ~clk;

  reg_f_arbiter_if #(.WIDTH(WIDTH), .REG_F_SEL_SIZE(SEL_W)) bus ();

  reg_f_arbiter #(
    .WIDTH(WIDTH), .REG_SIZE(REG_SIZE), .REG_F_SEL_SIZE(SEL_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Register file behind the arbiter
  logic [WIDTH-1:0] mem [REG_SIZE];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < REG_SIZE; i++) mem[i] <= '0;
    end else if (bus.EN_REG_F && int'(bus.REG_F_SEL) < REG_SIZE) begin
      mem[bus.REG_F_SEL] <= bus.REG_IN;
    end
  end

  assign bus.REG_OUT = (int'(bus.REG_F_SEL) < REG_SIZE) ? mem[bus.REG_F_SEL] : '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs for one cycle and the outputs expected in it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             rst;
    logic             ar;  logic awe; logic [3:0] asel; logic [7:0] awd;
    logic             br;  logic bwe; logic [3:0] bsel; logic [7:0] bwd;
    logic             ga;  logic gb;  logic en; logic [3:0] sel; logic [7:0] rin;
    logic             ad;  logic bd;  logic ae; logic be;
    logic [7:0]       ard; logic [7:0] brd;
  } vec_t;

  localparam int N_VEC = 23;
  vec_t vecs [N_VEC];

  task automatic fill_vectors();
    //          rst ar awe asel awd    br bwe bsel bwd    ga gb en sel rin    ad bd ae be ard    brd
    // reset, then A writes 0x5A to reg 3 and reads it back
    vecs[0]  = '{1, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,0,0,4'd0,8'h00, 0,0,0,0,8'h00,8'h00};
    vecs[1]  = '{0, 1,1,4'd3,8'h5A, 0,0,4'd0,8'h00, 0,0,0,4'd0,8'h00, 0,0,0,0,8'h00,8'h00};
    vecs[2]  = '{0, 1,1,4'd3,8'h5A, 0,0,4'd0,8'h00, 1,0,1,4'd3,8'h5A, 0,0,0,0,8'h00,8'h00};
    vecs[3]  = '{0, 1,0,4'd3,8'h00, 0,0,4'd0,8'h00, 1,0,0,4'd3,8'h00, 1,0,0,0,8'h00,8'h00};
    vecs[4]  = '{0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 1,0,0,4'd0,8'h00, 1,0,0,0,8'h5A,8'h00};
    // B writes bad index 9
    vecs[5]  = '{0, 0,0,4'd0,8'h00, 1,1,4'd9,8'hFF, 0,0,0,4'd0,8'h00, 0,0,0,0,8'h5A,8'h00};
    vecs[6]  = '{0, 0,0,4'd0,8'h00, 1,1,4'd9,8'hFF, 0,1,0,4'd9,8'hFF, 0,0,0,0,8'h5A,8'h00};
    vecs[7]  = '{0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,1,0,4'd0,8'h00, 0,1,0,1,8'h5A,8'h00};
    // tie: B served last, so A wins; A then forced off after 4 accesses
    vecs[8]  = '{0, 1,1,4'd1,8'h11, 1,1,4'd2,8'h22, 0,0,0,4'd0,8'h00, 0,0,0,0,8'h5A,8'h00};
    vecs[9]  = '{0, 1,1,4'd1,8'h11, 1,1,4'd2,8'h22, 1,0,1,4'd1,8'h11, 0,0,0,0,8'h5A,8'h00};
    vecs[10] = '{0, 1,1,4'd1,8'h12, 1,1,4'd2,8'h22, 1,0,1,4'd1,8'h12, 1,0,0,0,8'h5A,8'h00};
    vecs[11] = '{0, 1,1,4'd1,8'h13, 1,1,4'd2,8'h22, 1,0,1,4'd1,8'h13, 1,0,0,0,8'h5A,8'h00};
    vecs[12] = '{0, 1,1,4'd1,8'h14, 1,1,4'd2,8'h22, 1,0,1,4'd1,8'h14, 1,0,0,0,8'h5A,8'h00};
    vecs[13] = '{0, 1,1,4'd1,8'h15, 1,1,4'd2,8'h22, 0,1,1,4'd2,8'h22, 1,0,0,0,8'h5A,8'h00};
    vecs[14] = '{0, 1,1,4'd1,8'h15, 0,0,4'd0,8'h00, 0,1,0,4'd0,8'h00, 0,1,0,0,8'h5A,8'h00};
    // A write burst interrupted by reset; write to reg 5 must be suppressed
    vecs[15] = '{0, 1,1,4'd4,8'h44, 0,0,4'd0,8'h00, 1,0,1,4'd4,8'h44, 0,0,0,0,8'h5A,8'h00};
    vecs[16] = '{1, 1,1,4'd5,8'h55, 1,0,4'd2,8'h00, 1,0,0,4'd0,8'h00, 1,0,0,0,8'h5A,8'h00};
    // first tie after reset goes to A; then both read back
    vecs[17] = '{0, 1,0,4'd4,8'h00, 1,0,4'd2,8'h00, 0,0,0,4'd0,8'h00, 0,0,0,0,8'h00,8'h00};
    vecs[18] = '{0, 1,0,4'd4,8'h00, 1,0,4'd2,8'h00, 1,0,0,4'd4,8'h00, 0,0,0,0,8'h00,8'h00};
    vecs[19] = '{0, 0,0,4'd0,8'h00, 1,0,4'd2,8'h00, 1,0,0,4'd0,8'h00, 1,0,0,0,8'h44,8'h00};
    vecs[20] = '{0, 0,0,4'd0,8'h00, 1,0,4'd2,8'h00, 0,1,0,4'd2,8'h00, 0,0,0,0,8'h44,8'h00};
    vecs[21] = '{0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,1,0,4'd0,8'h00, 0,1,0,0,8'h44,8'h22};
    vecs[22] = '{0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,0,0,4'd0,8'h00, 0,0,0,0,8'h44,8'h22};
  endtask

  task automatic step_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (requester index 0 = A, 1 = B; owner -1 = nobody)
  // ---------------------------------------------------------------------------
  int         m_owner, m_last, m_hold;
  logic       m_done [2];
  logic       m_err  [2];
  logic [7:0] m_rdata[2];
  logic [7:0] m_regs [REG_SIZE];

  logic       r_req [2];
  logic       r_we  [2];
  logic [3:0] r_sel [2];
  logic [7:0] r_wd  [2];

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_hold  = 0;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0; m_err[i] = 1'b0; m_rdata[i] = 8'h00;
    end
  endtask

  task automatic model_advance(input logic rst_now);
    int nxt;
    if (rst_now) begin
      model_reset();
      return;
    end
    nxt = m_owner;
    m_done[0] = 1'b0; m_done[1] = 1'b0;
    m_err[0]  = 1'b0; m_err[1]  = 1'b0;
    if (m_owner >= 0 && r_req[m_owner]) begin
      m_done[m_owner] = 1'b1;
      if (int'(r_sel[m_owner]) < REG_SIZE) begin
        if (r_we[m_owner]) m_regs[r_sel[m_owner]] = r_wd[m_owner];
        else               m_rdata[m_owner] = m_regs[r_sel[m_owner]];
      end else begin
        m_err[m_owner] = 1'b1;
      end
      m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
      if (r_req[1 - m_owner] && m_hold >= MAX_HOLD) nxt = 1 - m_owner;
    end else if (m_owner >= 0) begin
      nxt = r_req[1 - m_owner] ? 1 - m_owner : -1;
    end else begin
      if (r_req[0] && r_req[1]) nxt = 1 - m_last;
      else if (r_req[0])        nxt = 0;
      else if (r_req[1])        nxt = 1;
    end
    if (nxt != m_owner) begin
      m_hold = 0;
      if (nxt >= 0) m_last = nxt;
    end
    m_owner = nxt;
  endtask

  task automatic drive_inputs();
    bus.A_REQ = r_req[0]; bus.A_WE = r_we[0]; bus.A_SEL = r_sel[0]; bus.A_WDATA = r_wd[0];
    bus.B_REQ = r_req[1]; bus.B_WE = r_we[1]; bus.B_SEL = r_sel[1]; bus.B_WDATA = r_wd[1];
  endtask

  task automatic check_model(input logic rst_now);
    logic       acc;
    logic       bad;
    logic [3:0] e_sel;
    logic [7:0] e_in;
    acc   = (m_owner >= 0) && r_req[m_owner] && !rst_now;
    bad   = acc && (int'(r_sel[m_owner]) >= REG_SIZE);
    e_sel = acc ? r_sel[m_owner] : 4'd0;
    e_in  = acc ? r_wd[m_owner]  : 8'h00;
    check("rnd A_GNT",    32'(bus.A_GNT),    32'(m_owner == 0));
    check("rnd B_GNT",    32'(bus.B_GNT),    32'(m_owner == 1));
    check("rnd EN_REG_F", 32'(bus.EN_REG_F), 32'(acc && r_we[m_owner] && !bad));
    if (!bad) begin
      check("rnd REG_F_SEL", 32'(bus.REG_F_SEL), 32'(e_sel));
      check("rnd REG_IN",    32'(bus.REG_IN),    32'(e_in));
    end
    check("rnd A_DONE",  32'(bus.A_DONE),  32'(m_done[0]));
    check("rnd B_DONE",  32'(bus.B_DONE),  32'(m_done[1]));
    check("rnd A_ERR",   32'(bus.A_ERR),   32'(m_err[0]));
    check("rnd B_ERR",   32'(bus.B_ERR),   32'(m_err[1]));
    check("rnd A_RDATA", 32'(bus.A_RDATA), 32'(m_rdata[0]));
    check("rnd B_RDATA", 32'(bus.B_RDATA), 32'(m_rdata[1]));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    mem_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_sel[i] = 4'd0; r_wd[i] = 8'h00;
    end
    drive_inputs();
    fill_vectors();
    step_clock();
    mem_clr = 1'b0;

    // Directed table
    for (int v = 0; v < N_VEC; v++) begin
      rst = vecs[v].rst;
      bus.A_REQ = vecs[v].ar; bus.A_WE = vecs[v].awe; bus.A_SEL = vecs[v].asel; bus.A_WDATA = vecs[v].awd;
      bus.B_REQ = vecs[v].br; bus.B_WE = vecs[v].bwe; bus.B_SEL = vecs[v].bsel; bus.B_WDATA = vecs[v].bwd;
      #1;
      check($sformatf("vec%0d A_GNT", v),     32'(bus.A_GNT),     32'(vecs[v].ga));
      check($sformatf("vec%0d B_GNT", v),     32'(bus.B_GNT),     32'(vecs[v].gb));
      check($sformatf("vec%0d EN_REG_F", v),  32'(bus.EN_REG_F),  32'(vecs[v].en));
      check($sformatf("vec%0d REG_F_SEL", v), 32'(bus.REG_F_SEL), 32'(vecs[v].sel));
      check($sformatf("vec%0d REG_IN", v),    32'(bus.REG_IN),    32'(vecs[v].rin));
      check($sformatf("vec%0d A_DONE", v),    32'(bus.A_DONE),    32'(vecs[v].ad));
      check($sformatf("vec%0d B_DONE", v),    32'(bus.B_DONE),    32'(vecs[v].bd));
      check($sformatf("vec%0d A_ERR", v),     32'(bus.A_ERR),     32'(vecs[v].ae));
      check($sformatf("vec%0d B_ERR", v),     32'(bus.B_ERR),     32'(vecs[v].be));
      check($sformatf("vec%0d A_RDATA", v),   32'(bus.A_RDATA),   32'(vecs[v].ard));
      check($sformatf("vec%0d B_RDATA", v),   32'(bus.B_RDATA),   32'(vecs[v].brd));
      step_clock();
    end
    // The write issued in the reset cycle must not have reached reg 5.
    check("reset-cycle write suppressed", 32'(mem[5]), 32'h0);

    // Randomized run against the reference model
    rst     = 1'b1;
    mem_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_sel[i] = 4'd0; r_wd[i] = 8'h00;
    end
    drive_inputs();
    step_clock();
    mem_clr = 1'b0;
    model_reset();
    for (int i = 0; i < REG_SIZE; i++) m_regs[i] = 8'h00;

    for (int c = 0; c < N_RAND; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++) begin
        r_req[i] = ($urandom_range(0, 3) != 0);
        r_we[i]  = $urandom_range(0, 1) == 1;
        r_sel[i] = 4'($urandom_range(0, 10));
        r_wd[i]  = 8'($urandom);
      end
      drive_inputs();
      #1;
      check_model(rst);
      model_advance(rst);
      step_clock();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
